rr_reg_write_arbiter: RTL and testbench

- Round-robin arbiter that shares one DATA_W-wide D-register bank between NUM_REQ requesters using a valid/ready handshake.
- Each accepted request loads the requester's data into the register.
- An optional programmable gap of idle cycles follows every write.
- Sits between several producer blocks and a single shared holding register whose output feeds downstream logic.

---
 rtl/rr_reg_write_arbiter.sv | 141 ++++++++++++++
 tb/tb_rr_reg_write_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_reg_write_arbiter.sv
// Round-robin arbiter granting NUM_REQ valid/ready producers write access to
// one shared DATA_W holding register, with an optional idle gap after each write.
module rr_reg_write_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned GAP     = 1,
  localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      clr,
  output logic [DATA_W-1:0]         q,
  output logic                      q_valid,
  output logic [IDX_W-1:0]          q_owner,
  output logic [15:0]               wr_count,
  output logic                      busy
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned WC_W  = 16;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_GAP  = 1'b1
  } state_e;

  state_e             state, state_d;
  logic [CNT_W-1:0]   gap_cnt, gap_cnt_d;
  logic [IDX_W-1:0]   ptr, ptr_d;
  logic [IDX_W-1:0]   sel;
  logic [IDX_W-1:0]   cand;
  logic               sel_found;
  logic               grant;
  logic               hs;
  logic [DATA_W-1:0]  sel_data;

  // Rotating priority search starting at ptr
  always_comb begin
    sel       = '0;
    sel_found = 1'b0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((32'(ptr) + k) % NUM_REQ);
      if (!sel_found && req_valid[cand]) begin
        sel_found = 1'b1;
        sel       = cand;
      end
    end
  end

  // Grant is suppressed in reset, in the gap, and whenever clr is asserted
  assign grant = reset_n && (state == ST_IDLE) && !clr && sel_found;

  always_comb begin
    req_ready = '0;
    if (grant) begin
      req_ready[sel] = 1'b1;
    end
  end

  assign hs = |(req_valid & req_ready);

  // Winning requester's data word
  always_comb begin
    sel_data = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (IDX_W'(k) == sel) begin
        sel_data = req_data[k*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state logic for the write/gap sequencer and the pointer
  always_comb begin
    state_d   = state;
    gap_cnt_d = gap_cnt;
    ptr_d     = ptr;
    if (hs) begin
      ptr_d = IDX_W'((32'(sel) + 1) % NUM_REQ);
    end
    case (state)
      ST_IDLE: begin
        if (hs && (GAP > 0)) begin
          state_d   = ST_GAP;
          gap_cnt_d = CNT_W'(GAP - 1);
        end
      end
      ST_GAP: begin
        if (gap_cnt == '0) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt - CNT_W'(1);
        end
      end
      default: begin
        state_d   = ST_IDLE;
        gap_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      gap_cnt <= '0;
      ptr     <= '0;
      busy    <= 1'b0;
    end else begin
      state   <= state_d;
      gap_cnt <= gap_cnt_d;
      ptr     <= ptr_d;
      busy    <= (state_d == ST_GAP);
    end
  end

  // Shared register bank; clr and a write never coincide since clr blocks grant
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q        <= '0;
      q_valid  <= 1'b0;
      q_owner  <= '0;
      wr_count <= '0;
    end else begin
      if (clr) begin
        q       <= '0;
        q_valid <= 1'b0;
      end else if (hs) begin
        q       <= sel_data;
        q_valid <= 1'b1;
        q_owner <= sel;
      end
      if (hs) begin
        wr_count <= wr_count + WC_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_rr_reg_write_arbiter.sv
// Directed bench for rr_reg_write_arbiter: a GAP=1 instance and a GAP=0 instance,
// with expected writes queued at grant time and checked when the register updates.
module tb_rr_reg_write_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned IDX_W   = 2;

  typedef struct packed {
    logic [IDX_W-1:0]  owner;
    logic [DATA_W-1:0] data;
    logic [15:0]       cnt;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      rst_a = 1'b1;
  logic                      rst_b = 1'b1;
  logic [NUM_REQ-1:0]        valid_a, valid_b;
  logic [NUM_REQ*DATA_W-1:0] data_a, data_b;
  logic [NUM_REQ-1:0]        ready_a, ready_b;
  logic                      clr_a, clr_b;
  logic [DATA_W-1:0]         q_a, q_b;
  logic                      qv_a, qv_b;
  logic [IDX_W-1:0]          owner_a, owner_b;
  logic [15:0]               wr_a, wr_b;
  logic                      busy_a, busy_b;

  rr_reg_write_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .GAP(1)) dut_a (
    .clk(clk), .reset_n(rst_a), .req_valid(valid_a), .req_data(data_a),
    .req_ready(ready_a), .clr(clr_a), .q(q_a), .q_valid(qv_a),
    .q_owner(owner_a), .wr_count(wr_a), .busy(busy_a)
  );

  rr_reg_write_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .GAP(0)) dut_b (
    .clk(clk), .reset_n(rst_b), .req_valid(valid_b), .req_data(data_b),
    .req_ready(ready_b), .clr(clr_b), .q(q_b), .q_valid(qv_b),
    .q_owner(owner_b), .wr_count(wr_b), .busy(busy_b)
  );

  wr_t         sb_a[$];
  wr_t         sb_b[$];
  int          passed = 0;
  int          failed = 0;
  int          total  = 0;
  logic [15:0] exp_cnt_a;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic wr_t mk(input logic [IDX_W-1:0] o, input logic [DATA_W-1:0] d,
                             input logic [15:0] c);
    wr_t r;
    r.owner = o;
    r.data  = d;
    r.cnt   = c;
    return r;
  endfunction

  // Scoreboard pop for instance A, one unit after each handshake edge
  always @(posedge clk) begin : mon_a
    logic hs;
    wr_t  e;
    hs = rst_a && (|(valid_a & ready_a));
    if (hs) begin
      #1;
      chk("sb_a_pending", 32'(sb_a.size() != 0), 32'd1);
      if (sb_a.size() != 0) begin
        e = sb_a.pop_front();
        chk("wr_q_a", 32'(q_a), 32'(e.data));
        chk("wr_owner_a", 32'(owner_a), 32'(e.owner));
        chk("wr_count_a", 32'(wr_a), 32'(e.cnt));
        chk("wr_qv_a", 32'(qv_a), 32'd1);
      end
    end
  end

  always @(posedge clk) begin : mon_b
    logic hs;
    wr_t  e;
    hs = rst_b && (|(valid_b & ready_b));
    if (hs) begin
      #1;
      chk("sb_b_pending", 32'(sb_b.size() != 0), 32'd1);
      if (sb_b.size() != 0) begin
        e = sb_b.pop_front();
        chk("wr_q_b", 32'(q_b), 32'(e.data));
        chk("wr_owner_b", 32'(owner_b), 32'(e.owner));
        chk("wr_count_b", 32'(wr_b), 32'(e.cnt));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a   = 1'b0;
    rst_b   = 1'b0;
    valid_a = '1;
    valid_b = '1;
    clr_a   = 1'b0;
    clr_b   = 1'b0;
    data_a  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    data_b  = '0;
    #1;
    // Reset: no grant even with every request raised
    chk("rst_ready_a", 32'(ready_a), 32'd0);
    chk("rst_ready_b", 32'(ready_b), 32'd0);
    chk("rst_q_a", 32'(q_a), 32'd0);
    chk("rst_qv_a", 32'(qv_a), 32'd0);
    chk("rst_owner_a", 32'(owner_a), 32'd0);
    chk("rst_wr_a", 32'(wr_a), 32'd0);
    chk("rst_busy_a", 32'(busy_a), 32'd0);
    valid_a = '0;
    valid_b = '0;
    @(negedge clk);
    rst_a = 1'b1;
    rst_b = 1'b1;
    exp_cnt_a = '0;

    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      chk("idle_ready_a", 32'(ready_a), 32'd0);
    end
    chk("idle_q_a", 32'(q_a), 32'd0);
    chk("idle_qv_a", 32'(qv_a), 32'd0);
    chk("idle_wr_a", 32'(wr_a), 32'd0);

    // All four requesting: grants 0,1,2,3,0 with one gap cycle after each
    valid_a = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("rr_ready", 32'(ready_a), 32'(1 << (i % 4)));
      exp_cnt_a = exp_cnt_a + 16'd1;
      sb_a.push_back(mk(IDX_W'(i % 4), 8'hA0 + 8'(i % 4), exp_cnt_a));
      @(negedge clk);
      #1;
      chk("rr_gap_busy", 32'(busy_a), 32'd1);
      chk("rr_gap_ready", 32'(ready_a), 32'd0);
      if (i == 4) valid_a = '0;
      @(negedge clk);
    end

    // Requester 1 alone moves ptr to 2
    valid_a = 4'b0010;
    #1;
    chk("p1_ready", 32'(ready_a), 32'b0010);
    exp_cnt_a = exp_cnt_a + 16'd1;
    sb_a.push_back(mk(2'd1, 8'hA1, exp_cnt_a));
    @(negedge clk);
    valid_a = 4'b1010;
    @(negedge clk);
    #1;
    chk("p3_first_ready", 32'(ready_a), 32'b1000);
    exp_cnt_a = exp_cnt_a + 16'd1;
    sb_a.push_back(mk(2'd3, 8'hA3, exp_cnt_a));
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("p1_second_ready", 32'(ready_a), 32'b0010);
    exp_cnt_a = exp_cnt_a + 16'd1;
    sb_a.push_back(mk(2'd1, 8'hA1, exp_cnt_a));
    @(negedge clk);
    valid_a = '0;
    @(negedge clk);

    // ptr should now be 2: with 0,2,3 requesting, 2 wins
    valid_a = 4'b1101;
    #1;
    chk("ptr_probe_ready", 32'(ready_a), 32'b0100);
    exp_cnt_a = exp_cnt_a + 16'd1;
    sb_a.push_back(mk(2'd2, 8'hA2, exp_cnt_a));
    @(negedge clk);
    valid_a = '0;
    @(negedge clk);

    // clr beats a pending request in IDLE
    valid_a = 4'b0100;
    clr_a   = 1'b1;
    #1;
    chk("clr_ready", 32'(ready_a), 32'd0);
    @(negedge clk);
    clr_a = 1'b0;
    #1;
    chk("clr_q", 32'(q_a), 32'd0);
    chk("clr_qv", 32'(qv_a), 32'd0);
    chk("clr_wr_kept", 32'(wr_a), 32'(exp_cnt_a));
    chk("clr_owner_kept", 32'(owner_a), 32'd2);
    chk("clr_then_ready", 32'(ready_a), 32'b0100);
    exp_cnt_a = exp_cnt_a + 16'd1;
    sb_a.push_back(mk(2'd2, 8'hA2, exp_cnt_a));
    @(negedge clk);
    // clr during the gap clears q without stretching the gap
    valid_a = '0;
    clr_a   = 1'b1;
    #1;
    chk("gclr_busy", 32'(busy_a), 32'd1);
    @(negedge clk);
    clr_a = 1'b0;
    #1;
    chk("gclr_q", 32'(q_a), 32'd0);
    chk("gclr_qv", 32'(qv_a), 32'd0);
    chk("gclr_busy_done", 32'(busy_a), 32'd0);
    chk("gclr_wr", 32'(wr_a), 32'(exp_cnt_a));

    // Write 0x5A from requester 3, then async reset mid-gap
    @(negedge clk);
    data_a  = {8'h5A, 8'hA2, 8'hA1, 8'hA0};
    valid_a = 4'b1000;
    #1;
    chk("r5a_ready", 32'(ready_a), 32'b1000);
    exp_cnt_a = exp_cnt_a + 16'd1;
    sb_a.push_back(mk(2'd3, 8'h5A, exp_cnt_a));
    @(negedge clk);
    valid_a = '0;
    #1;
    chk("r5a_busy", 32'(busy_a), 32'd1);
    #1;
    rst_a = 1'b0;
    #1;
    chk("arst_q", 32'(q_a), 32'd0);
    chk("arst_qv", 32'(qv_a), 32'd0);
    chk("arst_busy", 32'(busy_a), 32'd0);
    chk("arst_wr", 32'(wr_a), 32'd0);
    @(negedge clk);
    rst_a     = 1'b1;
    exp_cnt_a = '0;
    valid_a   = 4'b1111;
    #1;
    chk("arst_restart_ready", 32'(ready_a), 32'b0001);
    exp_cnt_a = exp_cnt_a + 16'd1;
    sb_a.push_back(mk(2'd0, 8'hA0, exp_cnt_a));
    @(negedge clk);
    valid_a = '0;
    @(negedge clk);

    // GAP=0 instance: five back-to-back writes from requester 0
    valid_b = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      data_b = {24'h0, 8'h11 + 8'(i)};
      #1;
      chk("b2b_ready", 32'(ready_b), 32'b0001);
      chk("b2b_busy", 32'(busy_b), 32'd0);
      sb_b.push_back(mk(2'd0, 8'h11 + 8'(i), 16'(i + 1)));
      @(negedge clk);
    end
    valid_b = '0;
    #1;
    chk("b2b_q", 32'(q_b), 32'h15);
    chk("b2b_wr", 32'(wr_b), 32'd5);
    chk("b2b_busy_end", 32'(busy_b), 32'd0);

    @(negedge clk);
    chk("sb_a_drained", 32'(sb_a.size()), 32'd0);
    chk("sb_b_drained", 32'(sb_b.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
